// File: rtl/input_debounce_edge.sv
// input_debounce_edge: synchronizes and debounces a bouncy asynchronous input,
// producing a clean level plus one-cycle rise/fall strobes.
// Ports:
//   clk   - system clock, all state updates on posedge
//   reset - asynchronous active-low reset
//   in    - raw asynchronous input (may glitch/bounce)
//   out   - debounced, synchronized level (registered)
//   rise  - one-cycle strobe on out 0->1 (registered)
//   fall  - one-cycle strobe on out 1->0 (registered)
//   busy  - high while a candidate change is being timed (registered)
module input_debounce_edge #(
   parameter int CNT_W           = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall,
   output logic busy
);
   if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_param
      $fatal(1, "input_debounce_edge: DEBOUNCE_CYCLES out of range");
   end
   typedef enum logic {STABLE, PENDING} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             sync1, sync2;
   logic             out_n, rise_n, fall_n, commit;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      case (state)
         STABLE: begin
            cnt_n = '0;
            if (sync2 != out) begin
               // a one-cycle window needs no pending phase
               if (DEBOUNCE_CYCLES == 1) commit = 1'b1;
               else begin
                  state_n = PENDING;
                  cnt_n   = CNT_W'(1);
               end
            end
         end
         default: begin
            if (sync2 == out) begin
               // any matching sample restarts the window
               state_n = STABLE;
               cnt_n   = '0;
            end else if (cnt == LAST) commit = 1'b1;
            else cnt_n = cnt + 1'b1;
         end
      endcase
      if (commit) begin
         state_n = STABLE;
         cnt_n   = '0;
      end
      out_n  = commit ? sync2 : out;
      rise_n = commit & sync2;
      fall_n = commit & ~sync2;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= STABLE;
         cnt   <= '0;
         out   <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         sync1 <= in;
         sync2 <= sync1;
         state <= state_n;
         cnt   <= cnt_n;
         out   <= out_n;
         rise  <= rise_n;
         fall  <= fall_n;
         busy  <= (cnt_n != '0);
      end
   end
endmodule

// File: tb/tb_input_debounce_edge.sv
// tb_input_debounce_edge: scoreboard bench for input_debounce_edge at N=4 and N=1.
module tb_input_debounce_edge;
   typedef struct {int e; logic r;} ev_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_a = 1'b1, in_b = 1'b1;
   logic out_a, rise_a, fall_a, busy_a;
   logic out_b, rise_b, fall_b, busy_b;
   int   ec = 0;
   int   vectors = 0;
   int   miscompares = 0;
   ev_t  q_a[$];
   ev_t  q_b[$];
   input_debounce_edge #(.CNT_W(4), .DEBOUNCE_CYCLES(4)) dut_a (
      .clk(clk), .reset(reset), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
   );
   input_debounce_edge #(.CNT_W(2), .DEBOUNCE_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
   );
   always #5 clk = ~clk;
   always @(posedge clk) ec <= ec + 1;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, ec, act, exp);
      end
   endtask
   task automatic wait_edge(input int e);
      while (ec < e) @(negedge clk);
   endtask
   task automatic strobe(input string name, inout ev_t q[$], input logic r, input logic f, input logic o);
      ev_t x;
      vectors++;
      if (q.size() == 0) begin
         miscompares++;
         $display("FAIL %s unexpected strobe at edge %0d: rise=%b fall=%b out=%b", name, ec, r, f, o);
      end else begin
         x = q.pop_front();
         if (x.e != ec || r !== x.r || f !== ~x.r || o !== x.r) begin
            miscompares++;
            $display("FAIL %s strobe: got edge %0d rise=%b fall=%b out=%b, expected edge %0d rise=%b fall=%b out=%b",
                     name, ec, r, f, o, x.e, x.r, ~x.r, x.r);
         end
      end
   endtask
   always @(negedge clk) if (rise_a || fall_a) strobe("a", q_a, rise_a, fall_a, out_a);
   always @(negedge clk) if (rise_b || fall_b) strobe("b", q_b, rise_b, fall_b, out_b);
   initial begin
      int k, r;
      repeat (3) @(negedge clk);
      chk("rst_out_a", out_a, 0);
      chk("rst_rise_a", rise_a, 0);
      chk("rst_fall_a", fall_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_busy_b", busy_b, 0);
      in_a = 1'b0;
      in_b = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      in_a = 1'b1;
      k = ec + 1;
      q_a.push_back('{k + 5, 1'b1});
      wait_edge(k + 1); chk("press_busy_early", busy_a, 0);
      wait_edge(k + 2); chk("press_busy", busy_a, 1);
      wait_edge(k + 4); chk("press_out_before", out_a, 0);
      wait_edge(k + 5); chk("press_out", out_a, 1); chk("press_busy_done", busy_a, 0);
      wait_edge(k + 8); chk("press_hold", out_a, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_out", out_a, 0);
      chk("async_busy", busy_a, 0);
      chk("async_rise", rise_a, 0);
      chk("async_fall", fall_a, 0);
      @(negedge clk);
      @(negedge clk);
      chk("async_held", out_a, 0);
      reset = 1'b1;
      r = ec + 1;
      q_a.push_back('{r + 5, 1'b1});
      wait_edge(r + 4); chk("poweron_before", out_a, 0);
      wait_edge(r + 5); chk("poweron_out", out_a, 1);
      wait_edge(r + 8);
      in_a = 1'b0;
      k = ec + 1;
      q_a.push_back('{k + 5, 1'b0});
      wait_edge(k + 4); chk("release_before", out_a, 1);
      wait_edge(k + 5); chk("release_out", out_a, 0);
      wait_edge(k + 8);
      in_a = 1'b1;
      k = ec + 1;
      @(negedge clk) in_a = 1'b0;
      @(negedge clk) in_a = 1'b1;
      @(negedge clk) in_a = 1'b0;
      @(negedge clk) in_a = 1'b1;
      q_a.push_back('{k + 9, 1'b1});
      wait_edge(k + 3); chk("bounce_mid", out_a, 0);
      wait_edge(k + 8); chk("bounce_before", out_a, 0);
      wait_edge(k + 9); chk("bounce_out", out_a, 1);
      wait_edge(k + 12);
      in_a = 1'b0;
      k = ec + 1;
      q_a.push_back('{k + 5, 1'b0});
      wait_edge(k + 8); chk("bounce_release", out_a, 0);
      in_a = 1'b1;
      k = ec + 1;
      wait_edge(k + 2);
      in_a = 1'b0;
      wait_edge(k + 4); chk("near_busy", busy_a, 1);
      wait_edge(k + 5); chk("near_busy_drop", busy_a, 0);
      wait_edge(k + 10); chk("near_out", out_a, 0);
      in_b = 1'b1;
      k = ec + 1;
      q_b.push_back('{k + 2, 1'b1});
      wait_edge(k + 1); chk("n1_before", out_b, 0);
      wait_edge(k + 2); chk("n1_out", out_b, 1); chk("n1_busy", busy_b, 0);
      wait_edge(k + 4);
      in_b = 1'b0;
      k = ec + 1;
      @(negedge clk) in_b = 1'b1;
      q_b.push_back('{k + 2, 1'b0});
      q_b.push_back('{k + 3, 1'b1});
      wait_edge(k + 2); chk("n1_pulse_low", out_b, 0);
      wait_edge(k + 3); chk("n1_pulse_high", out_b, 1);
      wait_edge(k + 4); chk("n1_rise_width", rise_b, 0);
      wait_edge(k + 6);
      chk("missing_strobes_a", q_a.size(), 0);
      chk("missing_strobes_b", q_b.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
